// File: rtl/mac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_pkg                                                      |
// | Description : Shared widths, mode encodings and FSM states for the MAC.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mac_pkg;

  localparam int MAC_DW = 8;
  localparam int MAC_OW = 17;

  localparam logic MODE_SUMP = 1'b0;
  localparam logic MODE_TRI  = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    TRI_2 = 1'b1
  } mac_state_e;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_unit                                                     |
// | Description : Combinational multiply-add, in_1*in_2+in_add modulo 2^OW.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mac_unit
  import mac_pkg::*;
#(
  parameter int DW = MAC_DW,
  parameter int OW = MAC_OW
) (
  input  logic [OW-1:0] in_1,
  input  logic [DW-1:0] in_2,
  input  logic [OW-1:0] in_add,
  output logic [OW-1:0] mac_out
);

  logic [OW-1:0] w_in_2_ext;

  // Evaluating at OW bits gives the modulo-2^OW wrap for free.
  assign w_in_2_ext = {{(OW-DW){1'b0}}, in_2};
  assign mac_out    = (in_1 * w_in_2_ext) + in_add;

endmodule : mac_unit
`default_nettype wire

// File: rtl/mac_top_level.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_top_level                                                |
// | Description : Trinomial / sum-of-products MAC with a two-state control FSM.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mac_top_level
  import mac_pkg::*;
#(
  parameter int DW = MAC_DW,
  parameter int OW = MAC_OW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mode,
  input  logic          valid_input,
  input  logic          last_input,
  input  logic [DW-1:0] num_a,
  input  logic [DW-1:0] num_x,
  input  logic [DW-1:0] num_b,
  input  logic [DW-1:0] num_c,
  output logic [OW-1:0] final_output,
  output logic          valid_output
);

  localparam logic [0:0] c_ST_IDLE  = IDLE;
  localparam logic [0:0] c_ST_TRI_2 = TRI_2;

  logic [0:0]    r_state;
  logic [DW-1:0] r_x_lat;
  logic [DW-1:0] r_c_lat;
  logic [OW-1:0] r_temp;
  logic [OW-1:0] r_acc;
  logic [OW-1:0] r_final_output;
  logic          r_valid_output;

  logic [OW-1:0] w_in_1;
  logic [DW-1:0] w_in_2;
  logic [OW-1:0] w_in_add;
  logic [OW-1:0] w_mac_out;

  // The single multiply-add is shared: second trinomial pass in TRI_2,
  // first pass or accumulation step in IDLE.
  always_comb begin
    w_in_1   = r_temp;
    w_in_2   = r_x_lat;
    w_in_add = {{(OW-DW){1'b0}}, r_c_lat};
    if (r_state == c_ST_IDLE) begin
      w_in_1   = {{(OW-DW){1'b0}}, num_a};
      w_in_2   = num_x;
      w_in_add = (mode == MODE_TRI) ? {{(OW-DW){1'b0}}, num_b} : r_acc;
    end
  end

  mac_unit #(
    .DW (DW),
    .OW (OW)
  ) u_mac_unit (
    .in_1    (w_in_1),
    .in_2    (w_in_2),
    .in_add  (w_in_add),
    .mac_out (w_mac_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= c_ST_IDLE;
      r_x_lat        <= '0;
      r_c_lat        <= '0;
      r_temp         <= '0;
      r_acc          <= '0;
      r_final_output <= '0;
      r_valid_output <= 1'b0;
    end else begin
      r_valid_output <= 1'b0;
      if (r_state == c_ST_TRI_2) begin
        r_final_output <= w_mac_out;
        r_valid_output <= 1'b1;
        r_state        <= c_ST_IDLE;
      end else if (valid_input) begin
        if (mode == MODE_TRI) begin
          r_x_lat <= num_x;
          r_c_lat <= num_c;
          r_temp  <= w_mac_out;
          r_state <= c_ST_TRI_2;
        end else begin
          // Every sample publishes its running sum; only the last one strobes.
          r_final_output <= w_mac_out;
          r_valid_output <= last_input;
          r_acc          <= last_input ? '0 : w_mac_out;
        end
      end
    end
  end

  assign final_output = r_final_output;
  assign valid_output = r_valid_output;

endmodule : mac_top_level
`default_nettype wire

// File: tb/tb_mac_top_level.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mac_top_level                                             |
// | Description : Self-checking bench for mac_top_level with reference model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mac_top_level;

  localparam int DW = 8;
  localparam int OW = 17;
  localparam int unsigned MODV = 32'd1 << OW;

  logic          clk;
  logic          reset;
  logic          mode;
  logic          valid_input;
  logic          last_input;
  logic [DW-1:0] num_a;
  logic [DW-1:0] num_x;
  logic [DW-1:0] num_b;
  logic [DW-1:0] num_c;
  logic [OW-1:0] final_output;
  logic          valid_output;

  int checks;
  int failures;

  mac_top_level #(.DW(DW), .OW(OW)) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .valid_input  (valid_input),
    .last_input   (last_input),
    .num_a        (num_a),
    .num_x        (num_x),
    .num_b        (num_b),
    .num_c        (num_c),
    .final_output (final_output),
    .valid_output (valid_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned tri_ref(input int unsigned a, x, b, c);
    return ((a * x + b) * x + c) % MODV;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, v, l, input int unsigned a, x, b, c);
    mode        = m;
    valid_input = v;
    last_input  = l;
    num_a       = DW'(a);
    num_x       = DW'(x);
    num_b       = DW'(b);
    num_c       = DW'(c);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (final_output !== '0) begin
      failures++;
      $display("FAIL reset_final: got %0d want 0", final_output);
    end
    checks++;
    if (valid_output !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %0b want 0", valid_output);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_trinomial();
    int unsigned tv [3][5] = '{'{5, 3, 2, 1, 52}, '{9, 8, 7, 6, 638},
                               '{255, 255, 255, 255, 511}};
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, tv[i][0], tv[i][1], tv[i][2], tv[i][3]);
      tick();
      drive(1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (valid_output !== 1'b0) begin
        failures++;
        $display("FAIL tri%0d_early_valid: got %0b want 0", i, valid_output);
      end
      tick();
      checks++;
      if (final_output !== OW'(tv[i][4]) || valid_output !== 1'b1) begin
        failures++;
        $display("FAIL tri%0d_result: got %0d/v%0b want %0d/v1", i, final_output,
                 valid_output, tv[i][4]);
      end
      tick();
      checks++;
      if (valid_output !== 1'b0 || final_output !== OW'(tv[i][4])) begin
        failures++;
        $display("FAIL tri%0d_strobe_len: got %0d/v%0b want %0d/v0", i, final_output,
                 valid_output, tv[i][4]);
      end
    end
  endtask

  task automatic test_back_to_back_tri();
    drive(1, 1, 0, 5, 3, 2, 1);
    tick();
    drive(1, 1, 0, 9, 8, 7, 6);
    tick();
    checks++;
    if (final_output !== OW'(52) || valid_output !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: got %0d/v%0b want 52/v1", final_output, valid_output);
    end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (valid_output !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap: got v%0b want v0", valid_output);
    end
    tick();
    checks++;
    if (final_output !== OW'(638) || valid_output !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second: got %0d/v%0b want 638/v1", final_output, valid_output);
    end
    tick();
  endtask

  task automatic test_sum_of_products();
    int unsigned sv [4][4] = '{'{5, 3, 0, 15}, '{9, 8, 0, 87}, '{2, 4, 1, 95},
                               '{1, 1, 1, 1}};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, sv[i][2][0], sv[i][0], sv[i][1], 0, 0);
      tick();
      checks++;
      if (final_output !== OW'(sv[i][3]) || valid_output !== sv[i][2][0]) begin
        failures++;
        $display("FAIL sump%0d: got %0d/v%0b want %0d/v%0d", i, final_output,
                 valid_output, sv[i][3], sv[i][2]);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (final_output !== OW'(1) || valid_output !== 1'b0) begin
      failures++;
      $display("FAIL sump_idle_hold: got %0d/v%0b want 1/v0", final_output, valid_output);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, (i == 2), 255, 255, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (final_output !== OW'(64003) || valid_output !== 1'b1) begin
      failures++;
      $display("FAIL sump_overflow: got %0d/v%0b want 64003/v1", final_output, valid_output);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    drive(0, 1, 0, 7, 7, 0, 0);
    tick();
    drive(1, 1, 0, 5, 3, 2, 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (final_output !== '0 || valid_output !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got %0d/v%0b want 0/v0", final_output, valid_output);
    end
    tick();
    #2;
    reset = 1'b1;
    tick();
    checks++;
    if (valid_output !== 1'b0 || final_output !== '0) begin
      failures++;
      $display("FAIL reset_abort: got %0d/v%0b want 0/v0", final_output, valid_output);
    end
    drive(0, 1, 1, 2, 2, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (final_output !== OW'(4) || valid_output !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_sump: got %0d/v%0b want 4/v1", final_output, valid_output);
    end
    tick();
  endtask

  // Transaction-level model: a trinomial request occupies the block for one
  // extra cycle and its answer is the full polynomial; packets sum products.
  task automatic test_random();
    int unsigned acc      = 0;
    int unsigned exp_fin  = 4;
    bit          exp_val  = 0;
    bit          busy     = 0;
    int unsigned pend_res = 0;
    int unsigned a, x, b, c;
    bit          m, v, l;
    for (int n = 0; n < 400; n++) begin
      m = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
      x = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      c = $urandom_range(0, 255);
      drive(m, v, l, a, x, b, c);
      exp_val = 0;
      if (busy) begin
        exp_fin = pend_res;
        exp_val = 1;
        busy    = 0;
      end else if (v) begin
        if (m) begin
          busy     = 1;
          pend_res = tri_ref(a, x, b, c);
        end else begin
          exp_fin = (acc + a * x) % MODV;
          exp_val = l;
          acc     = l ? 0 : exp_fin;
        end
      end
      tick();
      checks++;
      if (final_output !== OW'(exp_fin) || valid_output !== exp_val) begin
        failures++;
        $display("FAIL random[%0d]: got %0d/v%0b want %0d/v%0b", n, final_output,
                 valid_output, exp_fin, exp_val);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_trinomial();
    test_back_to_back_tri();
    test_sum_of_products();
    test_overflow();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mac_top_level
`default_nettype wire

// File: doc/mac_top_level.md
Name:
mac_top_level

Overview:
- Multiply-accumulate datapath block with its own control FSM.
- Two modes, selected by `mode`:
  - Trinomial evaluation (a*x+b)*x+c, computed in two passes through one shared multiply-add unit.
  - Sum-of-products accumulation y += a*x over a packet terminated by `last_input`.
- Sits between an upstream operand source (valid/last framing) and a downstream result consumer (`valid_output` strobe).

Parameters:
- DW, 8, operand width of num_a/b/c/x.
- OW, 17, result/accumulator width. All arithmetic wraps modulo 2^OW.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- mode  input  1  1 = trinomial, 0 = sum-of-products. Sampled only on an accepted input.
- valid_input  input  1  operands valid this cycle.
- last_input  input  1  final sample of a sum-of-products packet. Ignored in trinomial mode.
- num_a  input  DW  coefficient a / multiplicand.
- num_x  input  DW  variable x / multiplier.
- num_b  input  DW  coefficient b (trinomial only).
- num_c  input  DW  coefficient c (trinomial only).
- final_output  output  OW  registered result.
- valid_output  output  1  one-cycle strobe: final_output holds a completed result.

Behaviour:
- Reset (reset=0, asynchronous):
  - final_output=0, valid_output=0, accumulator=0, temp=0, FSM=IDLE.
  - Reset mid-operation aborts the operation; no valid_output follows.
- All arithmetic is unsigned. Results are truncated to OW bits.
- Shared unit: mac_out = (in_1*in_2 + in_add) mod 2^OW.
- FSM states: IDLE, TRI_2.
  - An input is accepted only when the FSM is in IDLE and valid_input=1.
- IDLE, accept with mode=1 at edge T:
  - Latch x and c.
  - temp <= a*x+b.
  - Next state TRI_2. valid_output <= 0.
- TRI_2 at edge T+1:
  - final_output <= temp*x_latched + c_latched (mod 2^17).
  - valid_output <= 1.
  - Next state IDLE.
  - Result is visible, with valid_output high, during the cycle after edge T+1 (latency 2 edges from capture).
  - valid_input is ignored while in TRI_2.
  - A new input may be accepted in the cycle valid_output is high.
  - Trinomial operations leave the accumulator untouched.
- IDLE, accept with mode=0 at edge T (single edge, no state change):
  - s = accumulator + a*x.
  - final_output <= s.
  - valid_output <= last_input.
  - accumulator <= last_input ? 0 : s.
  - Every accepted sample updates final_output. valid_output is asserted only for the last sample of a packet.
- No accept, or invalid cycle:
  - valid_output <= 0.
  - final_output, accumulator and temp hold their values.
- Back-to-back sum-of-products samples (valid every cycle) are all accepted, one per cycle.
- Consecutive trinomial requests are accepted at most every 2 cycles.

Decomposition:
- Package mac_pkg:
  - DW and OW constants.
  - MODE_SUMP=0 and MODE_TRI=1 constants.
  - FSM state enum {IDLE, TRI_2}.
- Sub-module mac_unit: combinational in_1*in_2+in_add, OW-bit output.
- The top level holds the FSM, operand latches, temp, accumulator and output registers.

Test Plan:
- Trinomial a=5,x=3,b=2,c=1 → 2 edges later final_output=52, valid_output high for exactly 1 cycle.
- Trinomial a=9,x=8,b=7,c=6 → final_output=638.
- Trinomial all operands 255 → final_output=511 (wrap of 16646655 mod 131072).
- Trinomial a=5,x=3,b=2,c=1 with valid_input held high through TRI_2 (operands changed to 9,8,7,6 in cycle 2) → the cycle-2 input is dropped; first result is 52, and the operands are re-accepted in the cycle valid_output is high.
- Sum-of-products, packet of 3 samples:
  - Samples (5,3,last=0), (9,8,last=0), (2,4,last=1) on consecutive cycles → final_output 15, 87, 95.
  - valid_output only after the third sample.
  - A following packet (1,1,last=1) → 1.
- Sum-of-products overflow: three samples 255*255, last on the third → 64003.
- Reset: assert reset=0 one cycle after a trinomial capture → outputs 0 immediately, no valid_output.
  - After release, sum-of-products (2,2,last=1) → 4.
